// File: rtl/cla_serial_add_ctrl.sv
// Nibble-serial WIDTH-bit add/subtract controller: one 4-bit carry-lookahead
// slice processes the operands LS nibble first over WIDTH/4 cycles.

module cla4_slice (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);
   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   always_comb begin
      g    = a & b;
      p    = a ^ b;
      c[0] = cin;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & cin);
      s    = p ^ c[3:0];
      cout = c[4];
   end
endmodule

module cla_serial_add_ctrl #(
   parameter  int WIDTH = 32,
   localparam int NIB   = WIDTH / 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             op_sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);
   localparam int CW = $clog2(NIB);

   // in_valid/in_ready and out_valid/out_ready are plain valid/ready pairs:
   // a transfer happens on any rising edge where both are high.
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [3:0] slice_s;
   logic       slice_cout;
   logic       accept;
   logic       last_nib;

   cla4_slice u_slice (
      .a    (a_sh_q[3:0]),
      .b    (b_sh_q[3:0]),
      .cin  (carry_q),
      .s    (slice_s),
      .cout (slice_cout)
   );

   assign accept   = (state_q == S_IDLE) && in_valid;
   assign last_nib = (cnt_q == CW'(NIB - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         sum_sh_q <= '0;
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         sum_q    <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         sum_sh_q <= sum_sh_d;
         a_msb_q  <= a_msb_d;
         b_msb_q  <= b_msb_d;
         sum_q    <= sum_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (in_valid) state_d = S_RUN;
         S_RUN:   if (last_nib) state_d = S_DONE;
         S_DONE:  if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Subtract is A + ~B + 1: B is inverted at acceptance and the +1 enters as
   // the initial carry, so cout=1 means "no borrow".
   always_comb begin
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      sum_sh_d = sum_sh_q;
      a_msb_d  = a_msb_q;
      b_msb_d  = b_msb_q;
      sum_d    = sum_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      if (accept) begin
         a_sh_d  = a;
         b_sh_d  = op_sub ? ~b : b;
         carry_d = op_sub;
         cnt_d   = '0;
         a_msb_d = a[WIDTH-1];
         b_msb_d = op_sub ? ~b[WIDTH-1] : b[WIDTH-1];
      end else if (state_q == S_RUN) begin
         a_sh_d   = a_sh_q >> 4;
         b_sh_d   = b_sh_q >> 4;
         sum_sh_d = {slice_s, sum_sh_q[WIDTH-1:4]};
         carry_d  = slice_cout;
         cnt_d    = cnt_q + 1'b1;
         if (last_nib) begin
            sum_d  = {slice_s, sum_sh_q[WIDTH-1:4]};
            cout_d = slice_cout;
            ovf_d  = (a_msb_q == b_msb_q) && (slice_s[3] != a_msb_q);
         end
      end
   end

   always_comb begin
      in_ready  = (state_q == S_IDLE);
      out_valid = (state_q == S_DONE);
      busy      = (state_q != S_IDLE);
      sum       = sum_q;
      cout      = cout_q;
      ovf       = ovf_q;
   end
endmodule
